matrix_mac_param: RTL and testbench

- Parametrised NxN matrix multiply-accumulate engine that computes C = A*B, or C += A*B when accumulate is requested.
- Successor to the fixed 3x3, 8-bit, unsigned, wrap-only matrix MAC. Adds generic N/width, a signed mode, an accumulate mode, optional saturation and a sticky overflow flag.
- Operands arrive on row-major packed buses. The block runs a start/busy/done handshake and sits beside the host datapath as a compute accelerator.

---
 rtl/matrix_mac_pkg.sv | 38 +++
 rtl/mac_lane.sv | 73 +++++++
 rtl/matrix_mac_param.sv | 113 +++++++++++
 tb/tb_matrix_mac_param.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_mac_pkg.sv
// Shared types and helpers for the parametrised matrix MAC engine.
// Holds the FSM state enum, packed-bus offset helper and AW range limits.
package matrix_mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  // Wide enough to express the limits of any practical AW.
  localparam int LIMW = 128;

  // Bit offset of row-major element (i,j) in an n x n bus of w-bit elements.
  function automatic int elem_off(input int i, input int j,
                                  input int n, input int w);
    return (i * n + j) * w;
  endfunction

  function automatic logic signed [LIMW-1:0] smax_lim(input int w);
    logic signed [LIMW-1:0] one;
    one = 1;
    return (one <<< (w - 1)) - one;
  endfunction

  function automatic logic signed [LIMW-1:0] smin_lim(input int w);
    logic signed [LIMW-1:0] one;
    one = 1;
    return -(one <<< (w - 1));
  endfunction

  function automatic logic signed [LIMW-1:0] umax_lim(input int w);
    logic signed [LIMW-1:0] one;
    one = 1;
    return (one <<< w) - one;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One accumulator lane: acc <= f(acc + a*b) with range check per step.
// Ports: a/b elements, mode_signed, seed/load, step; acc (next value), ovf.
module mac_lane
  import matrix_mac_pkg::*;
#(
  parameter int DW  = 8,
  parameter int AW  = 16,
  parameter int SAT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          mode_signed,
  input  logic [AW-1:0] seed,
  input  logic          load,
  input  logic          step,
  output logic [AW-1:0] acc,
  output logic          ovf
);

  localparam int XW = AW + 1;
  localparam int PW = 2 * DW;

  localparam logic signed [LIMW-1:0] SMAX_W = smax_lim(AW);
  localparam logic signed [LIMW-1:0] SMIN_W = smin_lim(AW);
  localparam logic signed [LIMW-1:0] UMAX_W = umax_lim(AW);
  localparam logic signed [XW-1:0] SMAX = SMAX_W[XW-1:0];
  localparam logic signed [XW-1:0] SMIN = SMIN_W[XW-1:0];
  localparam logic [XW-1:0] UMAX = UMAX_W[XW-1:0];

  logic [AW-1:0] acc_q;
  logic signed [PW-1:0] prod_s;
  logic [PW-1:0] prod_u;
  logic [XW-1:0] prod_x;
  logic [XW-1:0] acc_x;
  logic [XW-1:0] sum;

  // Operands are widened to PW first so the multiply is full precision.
  assign prod_s = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
  assign prod_u = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

  assign prod_x = mode_signed ? {{(XW-PW){prod_s[PW-1]}}, prod_s}
                              : {{(XW-PW){1'b0}}, prod_u};
  assign acc_x  = mode_signed ? {acc_q[AW-1], acc_q} : {1'b0, acc_q};
  assign sum    = acc_x + prod_x;

  // acc carries the post-step value so the top can capture it
  // on the same edge the lane commits its final term.
  always_comb begin
    acc = sum[AW-1:0];
    ovf = 1'b0;
    if (mode_signed) begin
      if ($signed(sum) > SMAX) begin
        ovf = 1'b1;
        if (SAT != 0) acc = SMAX[AW-1:0];
      end else if ($signed(sum) < SMIN) begin
        ovf = 1'b1;
        if (SAT != 0) acc = SMIN[AW-1:0];
      end
    end else if (sum > UMAX) begin
      ovf = 1'b1;
      if (SAT != 0) acc = UMAX[AW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else if (load) acc_q <= seed;
    else if (step) acc_q <= acc;
  end

endmodule

// File: rtl/matrix_mac_param.sv
// NxN matrix multiply-accumulate engine: C = A*B or C += A*B.
// Ports: start/busy/done handshake, a_flat/b_flat in, c_flat out, ovf.
module matrix_mac_param
  import matrix_mac_pkg::*;
#(
  parameter int N   = 3,
  parameter int DW  = 8,
  parameter int AW  = 16,
  parameter int SAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode_signed,
  input  logic              acc_en,
  input  logic [N*N*DW-1:0] a_flat,
  input  logic [N*N*DW-1:0] b_flat,
  output logic [N*N*AW-1:0] c_flat,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam int KW = $clog2(N);

  state_t state;
  logic [KW-1:0] k;
  logic [N*N*DW-1:0] a_q;
  logic [N*N*DW-1:0] b_q;
  logic sgn_q;
  logic load;
  logic step;
  logic [N*N*AW-1:0] c_nxt;
  logic [N*N-1:0] lane_ovf;

  assign load = (state == IDLE) && start;
  assign step = (state == MAC);

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      localparam int CO = elem_off(gi, gj, N, AW);
      logic [DW-1:0] a_el;
      logic [DW-1:0] b_el;
      logic [AW-1:0] seed;

      assign a_el = a_q[elem_off(gi, int'(k), N, DW) +: DW];
      assign b_el = b_q[elem_off(int'(k), gj, N, DW) +: DW];
      assign seed = acc_en ? c_flat[CO +: AW] : '0;

      mac_lane #(
        .DW (DW),
        .AW (AW),
        .SAT(SAT)
      ) u_lane (
        .clk        (clk),
        .rst        (rst),
        .a          (a_el),
        .b          (b_el),
        .mode_signed(sgn_q),
        .seed       (seed),
        .load       (load),
        .step       (step),
        .acc        (c_nxt[CO +: AW]),
        .ovf        (lane_ovf[gi*N+gj])
      );
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      k      <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      c_flat <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a_flat;
            b_q   <= b_flat;
            sgn_q <= mode_signed;
            ovf   <= 1'b0;
            k     <= '0;
            busy  <= 1'b1;
            state <= MAC;
          end
        end
        MAC: begin
          ovf <= ovf | (|lane_ovf);
          k   <= k + KW'(1);
          if (k == KW'(N - 1)) begin
            c_flat <= c_nxt;
            busy   <= 1'b0;
            done   <= 1'b1;
            k      <= '0;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mac_param.sv
// Self-checking bench for matrix_mac_param (wrap and saturating instances).
// Drives fixed and random operations against a plain-arithmetic model.
module tb_matrix_mac_param;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int NN = N * N;
  localparam int AB = NN * DW;
  localparam int CB = NN * AW;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic mode_signed;
  logic acc_en;
  logic [AB-1:0] a_flat;
  logic [AB-1:0] b_flat;
  logic [CB-1:0] c0, c1;
  logic busy0, done0, ovf0;
  logic busy1, done1, ovf1;

  logic [CB-1:0] mc0, mc1;
  bit mo0, mo1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  matrix_mac_param #(.N(N), .DW(DW), .AW(AW), .SAT(0)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_signed(mode_signed),
    .acc_en(acc_en), .a_flat(a_flat), .b_flat(b_flat), .c_flat(c0),
    .busy(busy0), .done(done0), .ovf(ovf0)
  );

  matrix_mac_param #(.N(N), .DW(DW), .AW(AW), .SAT(1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .mode_signed(mode_signed),
    .acc_en(acc_en), .a_flat(a_flat), .b_flat(b_flat), .c_flat(c1),
    .busy(busy1), .done(done1), .ovf(ovf1)
  );

  function automatic longint vd(input logic [DW-1:0] v, input bit sgn);
    return sgn ? longint'($signed(v)) : longint'(v);
  endfunction

  function automatic longint vc(input logic [AW-1:0] v, input bit sgn);
    return sgn ? longint'($signed(v)) : longint'(v);
  endfunction

  // Reference: sum terms in k order, range-check after each term.
  function automatic void model(input logic [AB-1:0] a, input logic [AB-1:0] b,
                                input logic [CB-1:0] cin, input bit sgn,
                                input bit acc, input bit sat,
                                output logic [CB-1:0] cout, output bit ov);
    longint s, lo, hi, md;
    md = longint'(1) <<< AW;
    lo = sgn ? -(md / 2) : 0;
    hi = sgn ? (md / 2 - 1) : (md - 1);
    ov = 1'b0;
    cout = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = acc ? vc(cin[(i*N+j)*AW +: AW], sgn) : 0;
        for (int k = 0; k < N; k++) begin
          s = s + vd(a[(i*N+k)*DW +: DW], sgn) * vd(b[(k*N+j)*DW +: DW], sgn);
          if (s < lo || s > hi) begin
            ov = 1'b1;
            if (sat) s = (s < lo) ? lo : hi;
            else begin
              s = s & (md - 1);
              if (sgn && s > hi) s = s - md;
            end
          end
        end
        cout[(i*N+j)*AW +: AW] = s[AW-1:0];
      end
    end
  endfunction

  function automatic logic [AB-1:0] pk8(input int v[NN]);
    logic [AB-1:0] r;
    for (int e = 0; e < NN; e++) r[e*DW +: DW] = DW'(v[e]);
    return r;
  endfunction

  function automatic logic [CB-1:0] pk16(input int v[NN]);
    logic [CB-1:0] r;
    for (int e = 0; e < NN; e++) r[e*AW +: AW] = AW'(v[e]);
    return r;
  endfunction

  function automatic logic [AB-1:0] rnd_mat();
    logic [AB-1:0] r;
    for (int e = 0; e < NN; e++) r[e*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  // Launch one operation, update both models, wait (bounded) for done.
  task automatic run_op(input logic [AB-1:0] a, input logic [AB-1:0] b,
                        input bit sgn, input bit acc,
                        output int lat, output int bcnt, output int wid);
    logic [CB-1:0] n0, n1;
    bit o0, o1, seen;
    model(a, b, mc0, sgn, acc, 1'b0, n0, o0);
    model(a, b, mc1, sgn, acc, 1'b1, n1, o1);
    mc0 = n0; mo0 = o0; mc1 = n1; mo1 = o1;
    @(negedge clk);
    a_flat = a; b_flat = b; mode_signed = sgn; acc_en = acc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcnt = 0; lat = -1; wid = 0; seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (busy0) bcnt++;
      if (done0) begin
        seen = 1'b1;
        lat = t;
      end else @(negedge clk);
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL op_timeout: done not seen within 20 cycles");
    end else begin
      wid = 1;
      @(negedge clk);
      if (done0) wid++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode_signed = 1'b0; acc_en = 1'b0;
    a_flat = '0; b_flat = '0;
    mc0 = '0; mc1 = '0; mo0 = 1'b0; mo1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (c0 !== '0) begin failures++; $display("FAIL rst_c: got %h want 0", c0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy0); end
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", done0); end
    checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL rst_ovf: got %b want 0", ovf0); end
    checks++; if (c1 !== '0) begin failures++; $display("FAIL rst_c_sat: got %h want 0", c1); end
  endtask

  task automatic test_basic();
    int av[NN] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int bv[NN] = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
    int cv[NN] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    int lat, bcnt, wid;
    run_op(pk8(av), pk8(bv), 1'b0, 1'b0, lat, bcnt, wid);
    checks++; if (c0 !== pk16(cv)) begin failures++; $display("FAIL basic_c: got %h want %h", c0, pk16(cv)); end
    checks++; if (c0 !== mc0) begin failures++; $display("FAIL basic_model: got %h want %h", c0, mc0); end
    checks++; if (bcnt !== N) begin failures++; $display("FAIL basic_busy_cycles: got %0d want %0d", bcnt, N); end
    checks++; if (lat !== N) begin failures++; $display("FAIL basic_latency: got %0d want %0d", lat, N); end
    checks++; if (wid !== 1) begin failures++; $display("FAIL basic_done_width: got %0d want 1", wid); end
    checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL basic_ovf: got %b want 0", ovf0); end
  endtask

  task automatic test_accumulate();
    int av[NN] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int bv[NN] = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
    int cv[NN] = '{60, 48, 36, 168, 138, 108, 276, 228, 180};
    int lat, bcnt, wid;
    run_op(pk8(av), pk8(bv), 1'b0, 1'b1, lat, bcnt, wid);
    checks++; if (c0 !== pk16(cv)) begin failures++; $display("FAIL acc_c: got %h want %h", c0, pk16(cv)); end
    checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL acc_ovf: got %b want 0", ovf0); end
  endtask

  task automatic test_signed_identity();
    int iv[NN] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    int mv[NN] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1};
    int uv[NN] = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
    logic [AB-1:0] ff;
    int lat, bcnt, wid;
    ff = '1;
    run_op(ff, pk8(iv), 1'b1, 1'b0, lat, bcnt, wid);
    checks++; if (c0 !== pk16(mv)) begin failures++; $display("FAIL signed_c: got %h want %h", c0, pk16(mv)); end
    checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL signed_ovf: got %b want 0", ovf0); end
    run_op(ff, pk8(iv), 1'b0, 1'b0, lat, bcnt, wid);
    checks++; if (c0 !== pk16(uv)) begin failures++; $display("FAIL unsigned_c: got %h want %h", c0, pk16(uv)); end
  endtask

  task automatic test_overflow();
    int wv[NN] = '{64003, 64003, 64003, 64003, 64003, 64003, 64003, 64003, 64003};
    int sv[NN] = '{65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535};
    int av[NN] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    logic [AB-1:0] ff;
    int lat, bcnt, wid;
    ff = '1;
    run_op(ff, ff, 1'b0, 1'b0, lat, bcnt, wid);
    checks++; if (c0 !== pk16(wv)) begin failures++; $display("FAIL ovf_wrap_c: got %h want %h", c0, pk16(wv)); end
    checks++; if (ovf0 !== 1'b1) begin failures++; $display("FAIL ovf_wrap_flag: got %b want 1", ovf0); end
    checks++; if (c1 !== pk16(sv)) begin failures++; $display("FAIL ovf_sat_c: got %h want %h", c1, pk16(sv)); end
    checks++; if (ovf1 !== 1'b1) begin failures++; $display("FAIL ovf_sat_flag: got %b want 1", ovf1); end
    @(negedge clk);
    checks++; if (ovf0 !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b want 1", ovf0); end
    run_op(pk8(av), pk8(av), 1'b0, 1'b0, lat, bcnt, wid);
    checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b want 0", ovf0); end
    checks++; if (ovf1 !== 1'b0) begin failures++; $display("FAIL ovf_clear_sat: got %b want 0", ovf1); end
    checks++; if (c1 !== mc1) begin failures++; $display("FAIL ovf_clear_sat_c: got %h want %h", c1, mc1); end
  endtask

  task automatic test_abort();
    int av[NN] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int bv[NN] = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
    int cv[NN] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    int lat, bcnt, wid, nd;
    @(negedge clk);
    a_flat = '1; b_flat = '1; mode_signed = 1'b0; acc_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (c0 !== '0) begin failures++; $display("FAIL abort_c: got %h want 0", c0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", busy0); end
    checks++; if (done0 !== 1'b0 || ovf0 !== 1'b0) begin
      failures++; $display("FAIL abort_done_ovf: got %b%b want 00", done0, ovf0);
    end
    @(negedge clk);
    rst = 1'b0;
    mc0 = '0; mc1 = '0; mo0 = 1'b0; mo1 = 1'b0;
    nd = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (done0) nd++;
    end
    checks++; if (nd !== 0) begin failures++; $display("FAIL abort_no_done: got %0d pulses want 0", nd); end
    run_op(pk8(av), pk8(bv), 1'b0, 1'b1, lat, bcnt, wid);
    checks++; if (c0 !== pk16(cv)) begin failures++; $display("FAIL abort_rerun_c: got %h want %h", c0, pk16(cv)); end
  endtask

  task automatic test_back_to_back();
    logic [AB-1:0] a1, a2, a3, bm;
    logic [CB-1:0] e1, e2, s1, s2;
    bit o1, o2, q1, q2;
    int t1, t2, nd;
    a1 = rnd_mat(); a2 = rnd_mat(); a3 = rnd_mat(); bm = rnd_mat();
    model(a1, bm, mc0, 1'b0, 1'b0, 1'b0, e1, o1);
    model(a2, bm, e1, 1'b0, 1'b0, 1'b0, e2, o2);
    model(a1, bm, mc1, 1'b0, 1'b0, 1'b1, s1, q1);
    model(a2, bm, s1, 1'b0, 1'b0, 1'b1, s2, q2);
    @(negedge clk);
    a_flat = a1; b_flat = bm; mode_signed = 1'b0; acc_en = 1'b0; start = 1'b1;
    @(negedge clk);
    a_flat = a2;
    t1 = -1; t2 = -1;
    for (int t = 0; t < 16; t++) begin
      if (done0) begin
        if (t1 < 0) begin
          t1 = t;
          checks++; if (c0 !== e1) begin failures++; $display("FAIL b2b_first_c: got %h want %h", c0, e1); end
        end else if (t2 < 0) begin
          t2 = t;
          start = 1'b0;
          checks++; if (c0 !== e2) begin failures++; $display("FAIL b2b_second_c: got %h want %h", c0, e2); end
          checks++; if (c1 !== s2) begin failures++; $display("FAIL b2b_second_sat_c: got %h want %h", c1, s2); end
          checks++; if (ovf0 !== o2) begin failures++; $display("FAIL b2b_ovf: got %b want %b", ovf0, o2); end
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    mc0 = e2; mc1 = s2; mo0 = o2; mo1 = q2;
    checks++; if (t1 !== N) begin failures++; $display("FAIL b2b_first_latency: got %0d want %0d", t1, N); end
    checks++; if (t2 - t1 !== N + 2) begin
      failures++; $display("FAIL b2b_period: got %0d want %0d", t2 - t1, N + 2);
    end
    model(a3, bm, mc0, 1'b0, 1'b0, 1'b0, e1, o1);
    model(a3, bm, mc1, 1'b0, 1'b0, 1'b1, s1, q1);
    @(negedge clk);
    a_flat = a3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a_flat = a2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int t = 0; t < 10; t++) begin
      if (done0) begin
        nd++;
        checks++; if (c0 !== e1) begin failures++; $display("FAIL ignore_start_c: got %h want %h", c0, e1); end
      end
      @(negedge clk);
    end
    mc0 = e1; mc1 = s1; mo0 = o1; mo1 = q1;
    checks++; if (nd !== 1) begin failures++; $display("FAIL ignore_start_count: got %0d want 1", nd); end
  endtask

  task automatic test_random();
    int lat, bcnt, wid;
    for (int it = 0; it < 24; it++) begin
      run_op(rnd_mat(), rnd_mat(), 1'($urandom), 1'($urandom), lat, bcnt, wid);
      checks++; if (c0 !== mc0) begin failures++; $display("FAIL rand_c[%0d]: got %h want %h", it, c0, mc0); end
      checks++; if (ovf0 !== mo0) begin failures++; $display("FAIL rand_ovf[%0d]: got %b want %b", it, ovf0, mo0); end
      checks++; if (c1 !== mc1) begin failures++; $display("FAIL rand_sat_c[%0d]: got %h want %h", it, c1, mc1); end
      checks++; if (ovf1 !== mo1) begin failures++; $display("FAIL rand_sat_ovf[%0d]: got %b want %b", it, ovf1, mo1); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_accumulate();
    test_signed_identity();
    test_overflow();
    test_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
